// File: rtl/fxp_div_pkg.sv
// Shared types and constants for the fixed-point restoring divider.
// Quotient is floor(dividend * 2^FRAC / divisor), saturated on divide-by-zero.
package fxp_div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    localparam int DW   = 16;
    localparam int VW   = 8;
    localparam int QW   = 24;
    localparam int FRAC = 8;
    localparam int CW   = 5;

    localparam logic [QW-1:0] QSAT = 24'hFFFFFF;

    // Counter value at which the final restoring step executes.
    function automatic logic [CW-1:0] last_step(input bit round);
        return round ? CW'(QW) : CW'(QW - 1);
    endfunction
endpackage

// File: rtl/fxp_div_step.sv
// One radix-2 restoring division step: shift in a numerator bit, then
// conditionally subtract the divisor and emit the quotient bit.
import fxp_div_pkg::*;

module fxp_div_step (
    input  logic [VW:0]   i_rem,
    input  logic          i_bit,
    input  logic [VW-1:0] i_divisor,
    output logic [VW:0]   o_rem_next,
    output logic          o_qbit
);
    logic [VW:0] w_rem_sh;
    logic [VW:0] w_div_ext;

    // The incoming remainder is always below the divisor, so its top bit is zero.
    assign w_rem_sh   = {i_rem[VW-1:0], i_bit};
    assign w_div_ext  = {1'b0, i_divisor};
    assign o_qbit     = (w_rem_sh >= w_div_ext);
    assign o_rem_next = o_qbit ? (w_rem_sh - w_div_ext) : w_rem_sh;
endmodule

// File: rtl/fxp_div_unit.sv
// Multi-cycle fixed-point divider: one quotient bit per cycle, optional
// round-to-nearest using one extra step, Done pulse with held result.
import fxp_div_pkg::*;

module fxp_div_unit #(
    parameter bit ROUND = 1'b0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic          o_busy,
    output logic          o_done,
    output logic [QW-1:0] o_quotient,
    output logic          o_div_zero
);
    localparam int QSW = QW + (ROUND ? 1 : 0);
    localparam logic [CW-1:0] LAST = last_step(ROUND);

    state_t              r_state;
    state_t              w_state_next;
    logic [CW-1:0]       r_count;
    logic [DW+FRAC-1:0]  r_num;
    logic [VW-1:0]       r_divisor;
    logic [VW:0]         r_rem;
    logic [QSW-1:0]      r_q;
    logic                r_busy;
    logic                r_done;
    logic [QW-1:0]       r_quotient;
    logic                r_div_zero;

    logic                w_accept;
    logic [VW:0]         w_rem_next;
    logic                w_qbit;
    logic [QW-1:0]       w_result;

    // A Start coinciding with Done is refused so the requester sees a clean handshake.
    assign w_accept = (r_state == IDLE) && i_start && !r_done;

    fxp_div_step u_step (
        .i_rem      (r_rem),
        .i_bit      (r_num[DW+FRAC-1]),
        .i_divisor  (r_divisor),
        .o_rem_next (w_rem_next),
        .o_qbit     (w_qbit)
    );

    generate
        if (ROUND) begin : g_round
            assign w_result = r_q[QSW-1:1] + QW'(r_q[0]);
        end else begin : g_trunc
            assign w_result = r_q;
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = (i_divisor == '0) ? FIN : RUN;
            RUN:  if (r_count == LAST) w_state_next = FIN;
            FIN:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept)
                r_count <= '0;
            else if (r_state == RUN)
                r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_num      <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_quotient <= '0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_num      <= {i_dividend, {FRAC{1'b0}}};
                r_divisor  <= i_divisor;
                r_rem      <= '0;
                r_q        <= '0;
                r_div_zero <= 1'b0;
                r_busy     <= 1'b1;
            end else if (r_state == RUN) begin
                // Once the numerator is exhausted, zeros shift in for the round step.
                r_rem <= w_rem_next;
                r_q   <= {r_q[QSW-2:0], w_qbit};
                r_num <= r_num << 1;
            end else if (r_state == FIN) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
                if (r_divisor == '0) begin
                    r_quotient <= QSAT;
                    r_div_zero <= 1'b1;
                end else begin
                    r_quotient <= w_result;
                end
            end
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_quotient;
    assign o_div_zero = r_div_zero;
endmodule

// File: doc/fxp_div_unit.md
# fxp_div_unit

Multi-cycle fixed-point divider that the CPU offloads program 2's inner divide to. It takes a 16-bit dividend and an 8-bit divisor and produces a 24-bit quotient equal to floor(dividend·2^8 / divisor). That result is exactly what the CPU writes to data memory bytes 4..6. It sits beside the datapath, loaded from register operands and read back when Done pulses, and computes by radix-2 restoring division, one quotient bit per cycle.

## Interface
- ROUND, 0: 0 truncates; 1 adds the half-LSB (the next quotient bit) and costs one extra cycle.
- Clk  input  1  clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request; sampled only in IDLE.
- Dividend  input  16  unsigned dividend, captured on the accepted Start.
- Divisor  input  8  unsigned divisor, captured on the accepted Start.
- Busy  output  1  high from the cycle after an accepted Start until Done.
- Done  output  1  one-cycle pulse; Quotient is valid in that cycle.
- Quotient  output  24  result; held stable from Done until the next accepted Start.
- DivZero  output  1  set with Done when Divisor==0; cleared on the next accepted Start.

## Operation
- States:
  - IDLE: Start=1 captures operands and clears DivZero.
    - Divisor==0 goes to FIN.
    - Otherwise goes to RUN with count=0.
  - RUN: one restoring step per cycle.
    - Step: rem = {rem[7:0], numerator bit}; if rem >= divisor, subtract and shift in quotient bit 1, else 0.
    - Numerator is {Dividend, 8'h00}, consumed MSB first.
  - RUN → FIN after N steps: N=24 when ROUND=0, N=25 when ROUND=1 (step 25 shifts in a 0 numerator bit).
  - FIN: drive Done=1 and load Quotient, then return to IDLE.
- Widths:
  - Partial remainder is 9 bits, so the compare never overflows.
  - Quotient shift register is 24 bits, plus 1 round bit when ROUND=1.
  - Iteration counter is 5 bits.
- Result:
  - ROUND=0: Quotient = q[23:0].
  - ROUND=1: Quotient = q[24:1] + q[0]. No overflow is possible: the maximum is 0xFFFF00, when the divisor is 1 and the result is exact.
- Divide by zero: Quotient = 24'hFFFFFF, DivZero=1.
- Start while Busy or in FIN is ignored. Operands are not re-captured and the result is unaffected.
- Start arriving in the same cycle as Done is ignored. The requester re-asserts it in the next cycle.
- Operands may change after the capture edge without effect.

## Timing
- Reset values: state IDLE; Busy=0, Done=0, Quotient=0, DivZero=0; remainder, count and shift register all 0.
- Latency, counting the Start capture edge as edge 0 (nonzero divisor):
  - Busy=1 after edge 0.
  - Done=1 after edge N+1: edge 25 for ROUND=0, edge 26 for ROUND=1.
  - Busy=0 in the same cycle as Done.
- Latency for a zero divisor: Done after edge 1, with no RUN cycles.
- Throughput: a new Start is accepted in the cycle after Done, giving one divide per N+2 cycles.
- Done is high for exactly one cycle.
- Reset asserted mid-RUN or in FIN:
  - All outputs return to reset values immediately (asynchronous reset).
  - No Done is issued.
  - After Reset is released, the first Start restarts cleanly.

## Structure
- Package fxp_div_pkg holds:
  - the state enum {IDLE, RUN, FIN};
  - widths DW=16, VW=8, QW=24, FRAC=8;
  - the saturation constant QSAT=24'hFFFFFF.
- Sub-module fxp_div_step is combinational: takes {rem, next bit, divisor} and returns {rem_next, qbit}. It is reusable if the block is later unrolled to 2 bits per cycle.
- All registers live in the top module: one always block for state and counter, one for the datapath.

## Test plan
- ROUND=0, Dividend=0x0003, Divisor=0xFF → Quotient=0x000003, DivZero=0, Done exactly 25 cycles after the Start edge.
- ROUND=1, Dividend=0x0002, Divisor=0x03 → Quotient=0x0000AB, Done at 26 cycles. The same operands with ROUND=0 → 0x0000AA.
- Dividend=0xFFFF, Divisor=0x01 → 0xFFFF00. Dividend=0x0000, Divisor=0x7F → 0x000000.
- Dividend=0x1234, Divisor=0x00 → Quotient=0xFFFFFF, DivZero=1, Done 1 cycle after the Start edge. A following Start with Divisor=0x03 clears DivZero.
- Start re-pulsed mid-RUN with different operands → first result unchanged and a single Done. A Start pulsed in the Done cycle is ignored. Then 1000 random operand pairs are checked against floor(a·256/b) and the ROUND variant.
- Reset asserted at RUN cycle 10 → Busy=0 and Quotient=0 immediately, no Done. A fresh Start then completes correctly.
